cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Completion stage directly downstream of the functional units (ALU, mult, branch, load).
//  Each FU presents a finished result.
//  The block captures it into a per-FU one-entry holding slot and returns a ready/ack to that FU.
//  Each cycle it round-robin selects up to CDB_W held results.
//  The selected results are broadcast on the registered common data bus.
//  Consumers of the bus are the reservation stations, the map table and the ROB.
// PARAMETERS
//  NUM_FU   4   number of functional-unit result sources
//  CDB_W    2   CDB broadcast lanes per cycle (2-way superscalar)
//  XLEN     32  result / branch-target width
//  TAG_W    5   ROB tag width
// PORTS
//  clock           in   1              system clock
//  reset           in   1              synchronous, active-high reset
//  squash          in   1              branch-mispredict flush, synchronous
//  fu_valid        in   NUM_FU         FU i presents a finished result
//  fu_tag          in   NUM_FU*TAG_W   ROB tag of FU i result
//  fu_value        in   NUM_FU*XLEN    result value of FU i
//  fu_take_branch  in   NUM_FU         branch resolved taken
//  fu_ready        out  NUM_FU         slot i empty; FU i may hand over this cycle
//  cdb_valid       out  CDB_W          lane k carries a broadcast
//  cdb_tag         out  CDB_W*TAG_W    ROB tag on lane k
//  cdb_value       out  CDB_W*XLEN     value on lane k
//  cdb_take_branch out  CDB_W          taken flag on lane k
// BEHAVIOUR
//  - Reset values: all slot_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag/value/take_branch=0, fu_ready=all 1.
//  - Handshake and capture:
//    - fu_ready[i] = ~slot_valid[i]. It is combinational from state only, with no path from fu_valid.
//    - Transfer occurs when fu_valid[i] && fu_ready[i]. The slot captures tag, value and take_branch at that edge.
//    - The FU holds its result while fu_ready[i]=0.
//  - Arbitration (combinational over slot_valid):
//    - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
//    - Grant the first min(CDB_W, #valid) slots.
//    - The j-th grant drives lane j. Unused lanes have cdb_valid=0 next cycle.
//  - Broadcast:
//    - Granted slot contents are registered onto the cdb_* outputs at the edge. Granted slots clear at the same edge.
//    - A cleared slot shows fu_ready=1 the following cycle; it is not re-fillable in the same cycle it drains.
//  - rr_ptr: on any grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU. With no grant, rr_ptr holds.
//  - Latency without bypass: fu_valid accepted at edge t -> slot valid in cycle t+1 -> cdb_valid in cycle t+2 (if granted).
//  - Ordering: no age ordering across FUs. Per FU, results leave in acceptance order, since one slot guarantees it.
//  - Squash (and reset):
//    - At the edge: all slots clear, cdb_valid <= 0, rr_ptr <= 0.
//    - A transfer presented in the squash cycle is discarded.
//    - Squash dominates capture and grant.
//  - Simultaneous events: NUM_FU slots valid with CDB_W lanes -> exactly CDB_W broadcast, the rest wait. Fairness is bounded: every held slot is granted within ceil(NUM_FU/CDB_W) cycles.
//  - Width rules: lane count and index arithmetic use $clog2(NUM_FU) bits with explicit mod-NUM_FU wrap. The design requires NUM_FU >= CDB_W.
// CONFIGURATION
//  CDB_ARB_BYPASS_EN defined:
//    - The arbiter also considers incoming transfers (fu_valid && fu_ready) as candidates in the same cycle.
//    - A granted incoming result is registered directly onto the CDB without touching the slot.
//    - Latency is fu_valid at t -> cdb_valid in t+1.
//    - fu_ready stays state-only. Bypass never changes its definition.
//  Undefined: two-cycle path as above. Slots are the only arbitration candidates.
// TESTING
//  1 Reset -> cdb_valid=00, fu_ready=1111, rr_ptr=0.
//  2 FU0 alone:
//    - Stimulus: tag=5, value=32'h0000_0042 for one cycle.
//    - Non-bypass: cdb lane0 valid=1, tag=5, value=0x42 two cycles later, lane1 valid=0.
//    - Bypass build: same response one cycle later.
//  3 All 4 FUs valid in the same cycle, tags 1..4:
//    - Broadcast 1,2 then 3,4 on consecutive cycles.
//    - rr_ptr 0 -> 2 -> 0.
//    - fu_ready[0..1] re-asserts one cycle before fu_ready[2..3].
//  4 Backpressure:
//    - FU2 slot held with tag=7 while FU2 presents tag=8 -> fu_ready[2]=0.
//    - Tag 8 is accepted only after tag 7 broadcasts.
//    - Tag 7 precedes tag 8 on the CDB.
//  5 Squash:
//    - Stimulus: squash with slots 1,3 valid and FU0 transferring.
//    - Next cycle: cdb_valid=00, fu_ready=1111.
//    - None of the three tags ever appear on the CDB.
//  6 Fairness: FU0 and FU1 re-present every cycle for 20 cycles -> FU2/FU3 held results broadcast within 2 cycles each.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Completion-stage bus: FU result handover plus registered CDB broadcast.
// master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_take_branch;
  logic [NUM_FU-1:0]       fu_ready;
  logic [CDB_W-1:0]        cdb_valid;
  logic [CDB_W*TAG_W-1:0]  cdb_tag;
  logic [CDB_W*XLEN-1:0]   cdb_value;
  logic [CDB_W-1:0]        cdb_take_branch;

  modport master (
    output fu_valid, fu_tag, fu_value, fu_take_branch,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value,
    input  cdb_take_branch
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_take_branch,
    output fu_ready, cdb_valid, cdb_tag, cdb_value,
    output cdb_take_branch
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU holding slots with round-robin selection onto a registered CDB.
// Define CDB_ARB_BYPASS_EN to let incoming transfers compete in the same cycle.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input logic          i_clock,
  input logic          i_reset,
  input logic          i_squash,
  cdb_arbiter_if.slave bus
);
  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW = $clog2(CDB_W + 1);
  localparam logic [PW:0]   NFU   = (PW+1)'(NUM_FU);
  localparam logic [CW-1:0] LANES = CW'(CDB_W);

  logic [NUM_FU-1:0]      r_slot_vld;
  logic [NUM_FU-1:0]      r_slot_br;
  logic [TAG_W-1:0]       r_slot_tag [NUM_FU];
  logic [XLEN-1:0]        r_slot_val [NUM_FU];
  logic [PW-1:0]          r_rr_ptr;
  logic [CDB_W-1:0]       r_cdb_vld;
  logic [CDB_W-1:0]       r_cdb_br;
  logic [CDB_W*TAG_W-1:0] r_cdb_tag;
  logic [CDB_W*XLEN-1:0]  r_cdb_val;

  logic [TAG_W-1:0]  w_in_tag [NUM_FU];
  logic [XLEN-1:0]   w_in_val [NUM_FU];
  logic [NUM_FU-1:0] w_cand;
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_cap;
  logic [PW-1:0]     w_lane_idx [CDB_W];
  logic [CDB_W-1:0]  w_lane_vld;
  logic [PW-1:0]     w_last;
  logic [PW-1:0]     w_rr_nxt;

  function automatic logic [PW-1:0] wrap(input logic [PW:0] s);
    logic [PW:0] t;
    t = (s >= NFU) ? s - NFU : s;
    return t[PW-1:0];
  endfunction

  always_comb begin : unpack
    for (int i = 0; i < NUM_FU; i++) begin
      w_in_tag[i] = bus.fu_tag[i*TAG_W +: TAG_W];
      w_in_val[i] = bus.fu_value[i*XLEN +: XLEN];
    end
  end

`ifdef CDB_ARB_BYPASS_EN
  assign w_cand = r_slot_vld | (bus.fu_valid & ~r_slot_vld);
`else
  assign w_cand = r_slot_vld;
`endif

  always_comb begin : arb
    logic [CW-1:0] cnt;
    logic [PW-1:0] idx;
    cnt        = '0;
    idx        = '0;
    w_grant    = '0;
    w_lane_vld = '0;
    w_last     = '0;
    for (int k = 0; k < CDB_W; k++) w_lane_idx[k] = '0;
    for (int o = 0; o < NUM_FU; o++) begin
      idx = wrap({1'b0, r_rr_ptr} + (PW+1)'(o));
      if (w_cand[idx] && cnt < LANES) begin
        for (int k = 0; k < CDB_W; k++) begin
          if (cnt == CW'(k)) begin
            w_lane_idx[k] = idx;
            w_lane_vld[k] = 1'b1;
          end
        end
        w_grant[idx] = 1'b1;
        w_last       = idx;
        cnt          = cnt + CW'(1);
      end
    end
  end

  assign w_rr_nxt = wrap({1'b0, w_last} + (PW+1)'(1));
  // a bypass-granted transfer goes straight to the CDB, never into the slot
  assign w_cap    = bus.fu_valid & ~r_slot_vld & ~w_grant;

  assign bus.fu_ready        = ~r_slot_vld;
  assign bus.cdb_valid       = r_cdb_vld;
  assign bus.cdb_tag         = r_cdb_tag;
  assign bus.cdb_value       = r_cdb_val;
  assign bus.cdb_take_branch = r_cdb_br;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_squash) begin
      r_slot_vld <= '0;
      r_rr_ptr   <= '0;
      r_cdb_vld  <= '0;
      r_cdb_br   <= '0;
      r_cdb_tag  <= '0;
      r_cdb_val  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_grant[i]) begin
          r_slot_vld[i] <= 1'b0;
        end else if (w_cap[i]) begin
          r_slot_vld[i] <= 1'b1;
          r_slot_tag[i] <= w_in_tag[i];
          r_slot_val[i] <= w_in_val[i];
          r_slot_br[i]  <= bus.fu_take_branch[i];
        end
      end
      if (|w_grant) r_rr_ptr <= w_rr_nxt;
      for (int k = 0; k < CDB_W; k++) begin
        r_cdb_vld[k] <= w_lane_vld[k];
        if (r_slot_vld[w_lane_idx[k]]) begin
          r_cdb_tag[k*TAG_W +: TAG_W] <= r_slot_tag[w_lane_idx[k]];
          r_cdb_val[k*XLEN +: XLEN]   <= r_slot_val[w_lane_idx[k]];
          r_cdb_br[k]                 <= r_slot_br[w_lane_idx[k]];
        end else begin
          r_cdb_tag[k*TAG_W +: TAG_W] <= w_in_tag[w_lane_idx[k]];
          r_cdb_val[k*XLEN +: XLEN]   <= w_in_val[w_lane_idx[k]];
          r_cdb_br[k]                 <= bus.fu_take_branch[w_lane_idx[k]];
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default two-cycle build).
// Table of per-cycle vectors plus a fairness sequence.
module tb_cdb_arbiter;
  localparam int NF = 4;
  localparam int CW = 2;
  localparam int XL = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst;
  logic sq;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NF), .CDB_W(CW), .XLEN(XL), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .CDB_W(CW), .XLEN(XL), .TAG_W(TW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_squash(sq),
    .bus     (bus)
  );

  typedef struct packed {
    logic            rst;
    logic            sq;
    logic [3:0]      v;
    logic [3:0][4:0] t;
    logic            ck;
    logic [3:0]      rdy;
    logic [1:0]      cv;
    logic [1:0][4:0] ct;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [19];

  function automatic logic [31:0] fval(input logic [4:0] t);
    return (t == 5'd5) ? 32'h0000_0042 : (32'hA000_0000 | (32'(t) * 7));
  endfunction

  function automatic vec_t mk(
    input logic r, input logic s, input logic [3:0] v,
    input logic [4:0] a, input logic [4:0] b,
    input logic [4:0] c, input logic [4:0] d,
    input logic ck, input logic [3:0] rd, input logic [1:0] cv,
    input logic [4:0] l0, input logic [4:0] l1);
    vec_t x;
    x.rst = r; x.sq = s; x.v = v;
    x.t = {d, c, b, a};
    x.ck = ck; x.rdy = rd; x.cv = cv;
    x.ct = {l1, l0};
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, ex);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][4:0] t);
    bus.fu_valid = v;
    bus.fu_tag   = t;
    for (int i = 0; i < NF; i++) begin
      bus.fu_value[i*XL +: XL] = fval(t[i]);
      bus.fu_take_branch[i]    = ^t[i];
    end
  endtask

  task automatic chk_lanes(input string nm, input logic [1:0] cv,
                           input logic [1:0][4:0] ct);
    chk({nm, "_cdb_valid"}, 32'(bus.cdb_valid), 32'(cv));
    for (int k = 0; k < CW; k++) begin
      if (cv[k]) begin
        chk({nm, "_tag"}, 32'(bus.cdb_tag[k*TW +: TW]), 32'(ct[k]));
        chk({nm, "_value"}, bus.cdb_value[k*XL +: XL], fval(ct[k]));
        chk({nm, "_br"}, 32'(bus.cdb_take_branch[k]), 32'(^ct[k]));
      end
    end
  endtask

  initial begin
    logic [2:0] seq [4];
    int ex [4];
    int streak [4];
    int nb [4];
    logic [3:0] will;
    logic [3:0][4:0] ft;
    logic [4:0] tg;
    logic [1:0] f;

    tbl[0]  = mk(1, 0, 4'h0, 0, 0, 0, 0,  0, 4'hF, 2'b00, 0, 0);
    tbl[1]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b00, 0, 0);
    tbl[2]  = mk(0, 0, 4'h1, 5, 0, 0, 0,  1, 4'hF, 2'b00, 0, 0);
    tbl[3]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hE, 2'b00, 0, 0);
    tbl[4]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b01, 5, 0);
    tbl[5]  = mk(0, 1, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b00, 0, 0);
    tbl[6]  = mk(0, 0, 4'hF, 1, 2, 3, 4,  1, 4'hF, 2'b00, 0, 0);
    tbl[7]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'h0, 2'b00, 0, 0);
    tbl[8]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'h3, 2'b11, 1, 2);
    tbl[9]  = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b11, 3, 4);
    tbl[10] = mk(0, 0, 4'h4, 0, 0, 7, 0,  1, 4'hF, 2'b00, 0, 0);
    tbl[11] = mk(0, 0, 4'h4, 0, 0, 8, 0,  1, 4'hB, 2'b00, 0, 0);
    tbl[12] = mk(0, 0, 4'h4, 0, 0, 8, 0,  1, 4'hF, 2'b01, 7, 0);
    tbl[13] = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hB, 2'b00, 0, 0);
    tbl[14] = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b01, 8, 0);
    tbl[15] = mk(0, 0, 4'hA, 0, 9, 0, 10, 1, 4'hF, 2'b00, 0, 0);
    tbl[16] = mk(0, 1, 4'h1, 11, 0, 0, 0, 1, 4'h5, 2'b00, 0, 0);
    tbl[17] = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b00, 0, 0);
    tbl[18] = mk(0, 0, 4'h0, 0, 0, 0, 0,  1, 4'hF, 2'b00, 0, 0);

    rst = 1'b1;
    sq  = 1'b0;
    drive(4'h0, '0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (tbl[i].ck) begin
        chk($sformatf("row%0d_ready", i), 32'(bus.fu_ready),
            32'(tbl[i].rdy));
        chk_lanes($sformatf("row%0d", i), tbl[i].cv, tbl[i].ct);
      end
      rst = tbl[i].rst;
      sq  = tbl[i].sq;
      drive(tbl[i].v, tbl[i].t);
    end

    // fairness: every FU re-presents as soon as it is accepted
    for (int i = 0; i < NF; i++) begin
      seq[i] = '0; ex[i] = 0; streak[i] = 0; nb[i] = 0;
    end
    will = '0;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      for (int k = 0; k < CW; k++) begin
        if (bus.cdb_valid[k]) begin
          tg = bus.cdb_tag[k*TW +: TW];
          f  = tg[4:3];
          chk("fair_order", 32'(tg), 32'({f, 3'(ex[f])}));
          chk("fair_value", bus.cdb_value[k*XL +: XL], fval(tg));
          ex[f]++;
          nb[f]++;
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (will[i]) seq[i] = seq[i] + 3'd1;
        if (!bus.fu_ready[i]) streak[i]++;
        else streak[i] = 0;
        chk($sformatf("fair_wait_fu%0d", i), 32'(streak[i] > 2), 32'd0);
        ft[i] = {2'(i), seq[i]};
      end
      if (c < 20) begin
        will = bus.fu_ready;
        drive(4'hF, ft);
      end else begin
        will = '0;
        drive(4'h0, ft);
      end
    end
    for (int i = 0; i < NF; i++)
      chk($sformatf("fair_count_fu%0d", i), 32'(nb[i]), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
